// File: rtl/systolic_array_sequencer.sv
// systolic_array_sequencer
// Initiator-side controller for a weight-stationary N x N systolic array.
// Accepts a weight matrix (cfg stream) and a stream of input vectors (x stream),
// drives the array's load/start controls and operand buses, holds start for a
// fixed settle window, captures the array result and returns it on the y stream.
//
// Ports
//   clk, reset            : single clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready   : weight-load handshake, cfg_weights = N*N elements
//   x_valid/x_ready       : input-vector handshake, x_data = N elements, x_last
//   y_valid/y_ready       : result handshake, y_data = N elements, y_last
//   arr_load_weights      : one-cycle weight load pulse to the array
//   arr_start             : held high for SETTLE_CYCLES per vector
//   arr_x, arr_w          : registered operand buses to the array
//   arr_y, arr_done       : array result and completion flag
//   vec_count             : results delivered since last cfg accept (wraps)
//   err_no_done           : sticky, set when arr_done is low at capture
module systolic_array_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 2 * N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [N*N*DATA_WIDTH-1:0]    cfg_weights,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic [N*DATA_WIDTH-1:0]      x_data,
    input  logic                         x_last,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [N*DATA_WIDTH-1:0]      y_data,
    output logic                         y_last,
    output logic                         arr_load_weights,
    output logic                         arr_start,
    output logic [N*DATA_WIDTH-1:0]      arr_x,
    output logic [N*N*DATA_WIDTH-1:0]    arr_w,
    input  logic [N*DATA_WIDTH-1:0]      arr_y,
    input  logic                         arr_done,
    output logic [15:0]                  vec_count,
    output logic                         err_no_done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_X,
        RUN,
        DRAIN,
        OUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             last_flag;

    // Handshake/control outputs are registered alongside the state so each one
    // is asserted exactly in the cycles its state is active, with no path from
    // any *_valid/*_ready input to an output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            last_flag        <= 1'b0;
            cfg_ready        <= 1'b1;
            x_ready          <= 1'b0;
            y_valid          <= 1'b0;
            y_last           <= 1'b0;
            y_data           <= '0;
            arr_load_weights <= 1'b0;
            arr_start        <= 1'b0;
            arr_x            <= '0;
            arr_w            <= '0;
            vec_count        <= '0;
            err_no_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        arr_w            <= cfg_weights;
                        vec_count        <= '0;
                        err_no_done      <= 1'b0;
                        cfg_ready        <= 1'b0;
                        arr_load_weights <= 1'b1;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    arr_load_weights <= 1'b0;
                    x_ready          <= 1'b1;
                    state            <= WAIT_X;
                end
                WAIT_X: begin
                    if (x_valid) begin
                        arr_x      <= x_data;
                        last_flag  <= x_last;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                        x_ready    <= 1'b0;
                        arr_start  <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Counter holds SETTLE_CYCLES in the first RUN cycle, so
                    // reaching 1 marks the last cycle of the settle window.
                    if (settle_cnt == CNT_W'(1)) begin
                        arr_start <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    y_data  <= arr_y;
                    if (!arr_done) begin
                        err_no_done <= 1'b1;
                    end
                    y_valid <= 1'b1;
                    y_last  <= last_flag;
                    state   <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid   <= 1'b0;
                        y_last    <= 1'b0;
                        vec_count <= vec_count + 16'd1;
                        if (last_flag) begin
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            x_ready <= 1'b1;
                            state   <= WAIT_X;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    cfg_ready        <= 1'b1;
                    x_ready          <= 1'b0;
                    y_valid          <= 1'b0;
                    arr_load_weights <= 1'b0;
                    arr_start        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb_systolic_array_sequencer
// Bench for systolic_array_sequencer: a behavioural array model sits on the
// array side, stimulus tasks drive cfg/x streams and push expected results
// into a scoreboard, and a monitor pops/compares on each y handshake.
// A second instance with SETTLE_CYCLES=1 covers the minimum settle window.
module tb_systolic_array_sequencer;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int S0 = 8;
    localparam int XW = N * DW;
    localparam int WW = N * N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [WW-1:0] cfg_weights = '0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [XW-1:0] x_data = '0;
    logic          x_last = 1'b0;
    logic          y_valid;
    logic          y_ready = 1'b1;
    logic [XW-1:0] y_data;
    logic          y_last;
    logic          arr_load_weights;
    logic          arr_start;
    logic [XW-1:0] arr_x;
    logic [WW-1:0] arr_w;
    logic [XW-1:0] arr_y = '0;
    logic          arr_done;
    logic [15:0]   vec_count;
    logic          err_no_done;

    // second instance, SETTLE_CYCLES = 1
    logic          s1_cfg_valid = 1'b0;
    logic          s1_cfg_ready;
    logic          s1_x_valid = 1'b0;
    logic          s1_x_ready;
    logic          s1_y_valid;
    logic [XW-1:0] s1_y_data;
    logic          s1_y_last;
    logic          s1_arr_load_weights;
    logic          s1_arr_start;
    logic [XW-1:0] s1_arr_x;
    logic [WW-1:0] s1_arr_w;
    logic [XW-1:0] s1_arr_y = 64'h0004_0003_0002_0001;
    logic [15:0]   s1_vec_count;
    logic          s1_err_no_done;
    logic [WW-1:0] s1_weights = '1;
    logic [XW-1:0] s1_xd = 64'h1111_2222_3333_4444;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  rand_ready = 1'b0;
    bit  force_nodone = 1'b0;

    typedef struct {
        logic [XW-1:0] y;
        logic          last;
        logic [15:0]   vc;
        logic          err;
        int            rise;
        int            stall;
    } exp_t;

    exp_t          sb[$];
    logic [WW-1:0] model_w = '0;
    logic [15:0]   model_vc = '0;
    logic          model_err = 1'b0;

    systolic_array_sequencer #(.DATA_WIDTH(DW), .N(N), .SETTLE_CYCLES(S0)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_weights(cfg_weights),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .arr_load_weights(arr_load_weights), .arr_start(arr_start),
        .arr_x(arr_x), .arr_w(arr_w), .arr_y(arr_y), .arr_done(arr_done),
        .vec_count(vec_count), .err_no_done(err_no_done)
    );

    systolic_array_sequencer #(.DATA_WIDTH(DW), .N(N), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .reset(reset),
        .cfg_valid(s1_cfg_valid), .cfg_ready(s1_cfg_ready), .cfg_weights(s1_weights),
        .x_valid(s1_x_valid), .x_ready(s1_x_ready), .x_data(s1_xd), .x_last(1'b1),
        .y_valid(s1_y_valid), .y_ready(1'b1), .y_data(s1_y_data), .y_last(s1_y_last),
        .arr_load_weights(s1_arr_load_weights), .arr_start(s1_arr_start),
        .arr_x(s1_arr_x), .arr_w(s1_arr_w), .arr_y(s1_arr_y), .arr_done(1'b1),
        .vec_count(s1_vec_count), .err_no_done(s1_err_no_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // y_j = sum_i x_i * W(i,j), modulo 2^DW
    function automatic logic [XW-1:0] matvec(input logic [WW-1:0] w, input logic [XW-1:0] x);
        logic [XW-1:0] r;
        int unsigned acc;
        r = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++)
                acc = acc + int'(x[i*DW +: DW]) * int'(w[(i*N+j)*DW +: DW]);
            r[j*DW +: DW] = DW'(acc & 32'hFFFF);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural array: latches weights on load, produces result and done
    // one edge after start is seen.
    logic [WW-1:0] arr_wstore = '0;
    logic          done_reg = 1'b0;
    always @(posedge clk) begin
        if (arr_load_weights) begin
            arr_wstore <= arr_w;
            done_reg   <= 1'b0;
        end
        if (arr_start) begin
            arr_y    <= matvec(arr_wstore, arr_x);
            done_reg <= 1'b1;
        end
    end
    assign arr_done = done_reg & ~force_nodone;

    // y_ready driver: stalls the requested number of cycles at the start of
    // each result, then ready (or random when rand_ready).
    int   stall_left = 0;
    logic yv_seen = 1'b0;
    always @(posedge clk) begin
        #1;
        if (y_valid && !yv_seen)
            stall_left = (sb.size() > 0) ? sb[0].stall : 0;
        if (y_valid && stall_left > 0) begin
            y_ready = 1'b0;
            stall_left--;
        end else begin
            y_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        yv_seen = y_valid;
    end

    // Monitor / scoreboard checker
    int            rise_cyc = 0;
    logic          mon_prev = 1'b0;
    logic [XW-1:0] hold_y = '0;
    logic          pend_vc = 1'b0;
    logic [15:0]   pend_vc_val = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            mon_prev = 1'b0;
            pend_vc  = 1'b0;
        end else begin
            if (pend_vc) begin
                chk("vec_count", vec_count, pend_vc_val);
                pend_vc = 1'b0;
            end
            if (y_valid) begin
                if (!mon_prev) begin
                    rise_cyc = cyc;
                    hold_y   = y_data;
                end else begin
                    chk("y_stable", y_data, hold_y);
                end
                chk("x_ready_during_out", x_ready, 0);
                if (y_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_y", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("y_data", y_data, e.y);
                        chk("y_last", y_last, e.last);
                        chk("err_no_done", err_no_done, e.err);
                        chk("y_rise_cycle", rise_cyc, e.rise);
                        pend_vc     = 1'b1;
                        pend_vc_val = e.vc;
                    end
                end
            end
            mon_prev = y_valid & ~y_ready;
        end
    end

    // Settle window and load pulse lengths
    int start_run = 0;
    int load_run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            start_run = 0;
            load_run  = 0;
        end else begin
            if (arr_start) start_run++;
            else if (start_run != 0) begin
                chk("arr_start_len", start_run, S0);
                start_run = 0;
            end
            if (arr_load_weights) load_run++;
            else if (load_run != 0) begin
                chk("arr_load_len", load_run, 1);
                load_run = 0;
            end
        end
    end

    task automatic reset_state_check(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_x_ready"}, x_ready, 0);
        chk({tag, "_y_valid"}, y_valid, 0);
        chk({tag, "_y_last"}, y_last, 0);
        chk({tag, "_y_data"}, y_data, 0);
        chk({tag, "_arr_load"}, arr_load_weights, 0);
        chk({tag, "_arr_start"}, arr_start, 0);
        chk({tag, "_arr_x"}, arr_x, 0);
        chk({tag, "_arr_w"}, arr_w, 0);
        chk({tag, "_vec_count"}, vec_count, 0);
        chk({tag, "_err"}, err_no_done, 0);
    endtask

    task automatic do_cfg(input logic [WW-1:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cfg_valid   = 1'b1;
        cfg_weights = w;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1'b1; break; end
        end
        chk("cfg_handshake_wait", ok, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        model_w   = w;
        model_vc  = '0;
        model_err = 1'b0;
        @(negedge clk);
        chk("cfg_load_pulse", arr_load_weights, 1);
        chk("cfg_arr_w", arr_w, w);
        chk("cfg_vc_clear", vec_count, 0);
        chk("cfg_err_clear", err_no_done, 0);
        chk("cfg_x_ready_early", x_ready, 0);
        @(negedge clk);
        chk("cfg_x_ready", x_ready, 1);
    endtask

    task automatic send_x(input logic [XW-1:0] x, input logic last, input int stall, input bit expect_out);
        bit   ok;
        int   t;
        exp_t e;
        ok = 1'b0;
        t  = 0;
        @(posedge clk); #1;
        x_valid = 1'b1;
        x_data  = x;
        x_last  = last;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (x_ready) begin ok = 1'b1; t = cyc; break; end
        end
        chk("x_handshake_wait", ok, 1);
        if (expect_out) begin
            model_vc = model_vc + 16'd1;
            if (force_nodone) model_err = 1'b1;
            e.y     = matvec(model_w, x);
            e.last  = last;
            e.vc    = model_vc;
            e.err   = model_err;
            e.rise  = t + S0 + 2;
            e.stall = stall;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cfg_ready && sb.size() == 0 && !pend_vc) begin ok = 1'b1; break; end
        end
        chk({tag, "_idle_wait"}, ok, 1);
    endtask

    function automatic logic [WW-1:0] rand_w();
        logic [WW-1:0] w;
        for (int i = 0; i < N * N; i++) w[i*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] x;
        for (int i = 0; i < N; i++) x[i*DW +: DW] = DW'($urandom);
        return x;
    endfunction

    initial begin
        logic [WW-1:0] ident;
        int            yv_cnt;
        int            len;
        int            t1;
        bit            ok;

        // reset
        repeat (3) @(posedge clk);
        #1 reset_state_check("rst");
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset_state_check("post_rst");

        // single vector, identity weights
        ident = '0;
        for (int i = 0; i < N; i++) ident[(i*N+i)*DW +: DW] = 16'd1;
        do_cfg(ident);
        send_x(64'h0004_0003_0002_0001, 1'b1, 0, 1'b1);
        wait_idle("single");
        chk("single_vec_count", vec_count, 1);
        chk("single_cfg_ready", cfg_ready, 1);

        // three back-to-back, stall on the second
        do_cfg(rand_w());
        send_x(rand_x(), 1'b0, 0, 1'b1);
        send_x(rand_x(), 1'b0, 5, 1'b1);
        send_x(rand_x(), 1'b1, 0, 1'b1);
        wait_idle("three");
        chk("three_vec_count", vec_count, 3);

        // array never signals done
        force_nodone = 1'b1;
        do_cfg(rand_w());
        send_x(rand_x(), 1'b0, 0, 1'b1);
        send_x(rand_x(), 1'b1, 2, 1'b1);
        wait_idle("nodone");
        chk("nodone_err_sticky", err_no_done, 1);
        force_nodone = 1'b0;
        do_cfg(rand_w());
        send_x(rand_x(), 1'b1, 0, 1'b1);
        wait_idle("after_nodone");

        // reset during the third RUN cycle
        do_cfg(rand_w());
        send_x(rand_x(), 1'b1, 0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("run3_start_high", arr_start, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_run_start_drop", arr_start, 0);
        chk("rst_run_cfg_ready", cfg_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        yv_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (y_valid) yv_cnt++;
        end
        chk("rst_run_no_y", yv_cnt, 0);
        chk("rst_run_vec_count", vec_count, 0);
        do_cfg(rand_w());
        send_x(rand_x(), 1'b1, 0, 1'b1);
        wait_idle("after_rst_run");

        // random batches with random ready
        rand_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            do_cfg(rand_w());
            len = $urandom_range(1, 4);
            for (int v = 0; v < len; v++)
                send_x(rand_x(), (v == len - 1), $urandom_range(0, 3), 1'b1);
            wait_idle("rand");
            chk("rand_vec_count", vec_count, len);
        end
        rand_ready = 1'b0;

        // SETTLE_CYCLES = 1 instance
        @(posedge clk); #1 s1_cfg_valid = 1'b1;
        @(posedge clk); #1 s1_cfg_valid = 1'b0;
        s1_x_valid = 1'b1;
        ok = 1'b0;
        t1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s1_x_ready) begin ok = 1'b1; t1 = cyc; break; end
        end
        chk("s1_x_handshake_wait", ok, 1);
        @(posedge clk); #1 s1_x_valid = 1'b0;
        @(negedge clk);
        chk("s1_start_t1", s1_arr_start, 1);
        chk("s1_arr_x", s1_arr_x, s1_xd);
        @(negedge clk);
        chk("s1_start_t2", s1_arr_start, 0);
        chk("s1_yv_t2", s1_y_valid, 0);
        @(negedge clk);
        chk("s1_yv_t3", s1_y_valid, 1);
        chk("s1_y_cycle", cyc - t1, 3);
        chk("s1_y_data", s1_y_data, 64'h0004_0003_0002_0001);
        chk("s1_y_last", s1_y_last, 1);
        @(negedge clk);
        chk("s1_cfg_ready_after", s1_cfg_ready, 1);
        chk("s1_vec_count", s1_vec_count, 1);
        chk("s1_err", s1_err_no_done, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_array_sequencer.md
# systolic_array_sequencer

Initiator-side controller for the weight-stationary N×N systolic array. It accepts a weight matrix and a stream of input vectors over valid/ready interfaces, and drives the array's `load_weights`, `start`, `x_in` and `w_in` controls. It holds `start` for a fixed settle window per vector, captures `y_out` on the array's `done`, and returns each result vector over a valid/ready output stream. It sits between the softmax datapath front end and the array instance.

## Interface
- `DATA_WIDTH`, 16, element width.
- `N`, 4, array dimension; vectors carry N elements, weights carry N×N.
- `SETTLE_CYCLES`, 2*N, cycles `arr_start` is held high per vector; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `cfg_valid` in 1 / `cfg_ready` out 1: weight-load handshake.
- `cfg_weights` in N*N*DATA_WIDTH: element (i,j) at `[(i*N+j)*DATA_WIDTH +: DATA_WIDTH]`.
- `x_valid` in 1 / `x_ready` out 1: input-vector handshake.
- `x_data` in N*DATA_WIDTH: element i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `x_last` in 1: marks the final vector of a batch.
- `y_valid` out 1 / `y_ready` in 1: result handshake.
- `y_data` out N*DATA_WIDTH: result vector, same packing as `x_data`.
- `y_last` out 1: copy of `x_last` for this result.
- `arr_load_weights` out 1, `arr_start` out 1: array controls.
- `arr_x` out N*DATA_WIDTH, `arr_w` out N*N*DATA_WIDTH: array operand buses, registered.
- `arr_y` in N*DATA_WIDTH, `arr_done` in 1: array result and done.
- `vec_count` out 16: results delivered since the last cfg accept; wraps at 2^16.
- `err_no_done` out 1: sticky flag; set when `arr_done` is low at capture.

## Operation
- FSM states: IDLE, LOAD, WAIT_X, RUN, DRAIN, OUT.
- IDLE: `cfg_ready`=1. On a cfg handshake, register `cfg_weights` into `arr_w`, clear `vec_count` and `err_no_done`, then go to LOAD.
- LOAD: `arr_load_weights`=1 for exactly one cycle, then go to WAIT_X.
- WAIT_X: `x_ready`=1. On an x handshake, register `x_data` into `arr_x` and `x_last` into a last flag, load the settle counter with SETTLE_CYCLES, then go to RUN.
- RUN: `arr_start`=1 and the counter decrements each cycle. When the counter reaches 1, go to DRAIN.
- DRAIN (one cycle): `arr_start`=0. Register `arr_y` into `y_data`. If `arr_done`=0, set `err_no_done`; capture proceeds regardless. Then go to OUT.
- OUT: `y_valid`=1 and `y_last`=last flag. `y_data` stays stable until the handshake. On `y_valid && y_ready`, increment `vec_count`, then go to IDLE if the last flag is set, otherwise to WAIT_X.
- `arr_w` and `arr_x` hold their values between updates. `arr_w` is not cleared between batches of the same cfg.
- `cfg_valid` outside IDLE and `x_valid` outside WAIT_X are ignored; no buffering.
- No arithmetic on data; widths pass through unchanged.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from `*_valid`/`*_ready` inputs to outputs.
- Reset values: state IDLE, so `cfg_ready`=1. All other outputs are 0: `x_ready`, `y_valid`, `y_last`, `y_data`, `arr_*`, `vec_count`, `err_no_done`.
- cfg handshake at cycle t: `arr_load_weights` high in cycle t+1 with `arr_w` valid; `x_ready` is high from t+2.
- x handshake at cycle t: `arr_start` is high during cycles t+1 … t+SETTLE_CYCLES; DRAIN is at t+SETTLE_CYCLES+1; `y_valid` rises at t+SETTLE_CYCLES+2. With defaults (N=4) this is t+10.
- After a non-last y handshake at cycle u, `x_ready` rises at u+1. Maximum throughput is one vector per SETTLE_CYCLES+3 cycles.
- `y_ready` held low stalls OUT indefinitely; `x_ready` stays low throughout.
- Reset asserted in any state forces IDLE and reset values asynchronously; `arr_start` and `arr_load_weights` drop immediately. The in-flight vector is discarded. After reset deasserts, a new cfg is required.
- `vec_count` wraps from 0xFFFF to 0 without a flag.

## Test plan
- Reset: hold `reset`=0 for 3 cycles → `cfg_ready`=1, all other outputs 0. Release, idle 5 cycles → no change.
- Single vector, N=4, identity weights, behavioural array model, `x_data`=[1,2,3,4], `x_last`=1 → `arr_load_weights` high exactly one cycle; `arr_start` high exactly 8 cycles; `y_valid` at t+10 with the model's result; `y_last`=1; `vec_count`=1; returns to IDLE with `cfg_ready`=1.
- Three vectors back-to-back, `y_ready` low for 5 cycles on the second → `x_ready` stays 0 while stalled; `y_data` stable; all three results correct and in order; `y_last` only on the third; `vec_count`=3.
- `arr_done` tied 0 → `err_no_done`=1 after the first DRAIN and stays set through later vectors. The next cfg accept clears it.
- `reset`=0 asserted in the 3rd RUN cycle → `arr_start`=0 in the same cycle, `y_valid` never rises. After release, the cfg+vector sequence completes normally.
- `SETTLE_CYCLES`=1 → `arr_start` high for a single cycle; `y_valid` at t+3.
